// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. queued auxiliary results.
// Optional cycle statistics are enabled with the WB_ARB_STATS_EN macro.
module wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        aux_valid,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_o,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic        pend1,
  output logic        pend2
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_full
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [4:0]        addr_mem_q [DEPTH];
  logic [4:0]        addr_mem_d [DEPTH];
  logic [31:0]       data_mem_q [DEPTH];
  logic [31:0]       data_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             empty;
  logic             full;
  logic             starve;
  logic             pipe_req;
  logic             accept;
  logic             push;
  logic             pop;
  logic             hit1;
  logic             hit2;
  logic             live;
  logic [PTR_W-1:0] offs;

  // A pipe write to $0 is no request; zero-address aux results are accepted but dropped.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_FULL);
    starve    = !rst && (wait_cnt_q == WAIT_LIMIT) && !empty;
    pipe_req  = pipe_we && (pipe_waddr != 5'd0);
    aux_ready = !rst && !full;
    accept    = aux_valid && aux_ready;
    push      = accept && (aux_waddr != 5'd0);
    pop       = !rst && !empty && (starve || !pipe_req);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    stall_o  = 1'b0;
    if (!rst) begin
      if (starve) begin
        stall_o  = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = addr_mem_q[rd_ptr_q];
        rf_wdata = data_mem_q[rd_ptr_q];
      end else if (pipe_req) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = addr_mem_q[rd_ptr_q];
        rf_wdata = data_mem_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wait_cnt_d = wait_cnt_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = aux_waddr;
      data_mem_d[wr_ptr_q] = aux_wdata;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Waiting time is measured only while the head sits blocked.
    if (pop || empty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  // The head being popped now is covered by the register-file write bypass.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    offs = '0;
    live = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      live = ({1'b0, offs} < count_q) && !(pop && (offs == '0));
      if (live && (addr_mem_q[i] == raddr1)) hit1 = 1'b1;
      if (live && (addr_mem_q[i] == raddr2)) hit2 = 1'b1;
    end
    if (accept && (aux_waddr == raddr1)) hit1 = 1'b1;
    if (accept && (aux_waddr == raddr2)) hit2 = 1'b1;
    pend1 = !rst && re1 && (raddr1 != 5'd0) && hit1;
    pend2 = !rst && re2 && (raddr2 != 5'd0) && hit2;
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_full_q, stat_full_d;

  always_comb begin
    stat_stall_d = stat_stall_q + {31'd0, stall_o};
    stat_full_d  = stat_full_q + {31'd0, (aux_valid && !aux_ready)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_full_q  <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_full_q  <= stat_full_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_full  = stat_full_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        aux_valid;
  logic [4:0]  aux_waddr;
  logic [31:0] aux_wdata;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_o;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;

  int errorCount = 0;
  int checkCount = 0;

  wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_o(stall_o),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .pend1(pend1), .pend2(pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued aux results as {addr, data} plus the head's blocked-cycle count.
  logic [36:0] mq[$];
  int          mwait = 0;

  function automatic void modelComb(output logic e_we, output logic [4:0] e_addr,
                                    output logic [31:0] e_data, output logic e_stall,
                                    output logic e_ready, output logic e_p1,
                                    output logic e_p2, output logic e_pop,
                                    output logic e_acc);
    logic h1, h2;
    e_we = 0; e_addr = 0; e_data = 0; e_stall = 0; e_ready = 0;
    e_p1 = 0; e_p2 = 0; e_pop = 0; e_acc = 0;
    h1 = 0; h2 = 0;
    if (rst) return;
    e_ready = (mq.size() < DEPTH);
    e_acc   = aux_valid && e_ready;
    if (mwait == MAX_WAIT && mq.size() != 0) begin
      e_stall = 1; e_we = 1; e_pop = 1;
      e_addr = mq[0][36:32]; e_data = mq[0][31:0];
    end else if (pipe_we && pipe_waddr != 0) begin
      e_we = 1; e_addr = pipe_waddr; e_data = pipe_wdata;
    end else if (mq.size() != 0) begin
      e_we = 1; e_pop = 1;
      e_addr = mq[0][36:32]; e_data = mq[0][31:0];
    end
    for (int i = (e_pop ? 1 : 0); i < mq.size(); i++) begin
      if (mq[i][36:32] == raddr1) h1 = 1;
      if (mq[i][36:32] == raddr2) h2 = 1;
    end
    if (e_acc && aux_waddr == raddr1) h1 = 1;
    if (e_acc && aux_waddr == raddr2) h2 = 1;
    e_p1 = re1 && raddr1 != 0 && h1;
    e_p2 = re2 && raddr2 != 0 && h2;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic        c_we, c_stall, c_ready, c_p1, c_p2, c_pop, c_acc;
  logic [4:0]  c_addr;
  logic [31:0] c_data;

  always @(negedge clk) begin
    modelComb(c_we, c_addr, c_data, c_stall, c_ready, c_p1, c_p2, c_pop, c_acc);
    checkOutput("rf_we",     32'(rf_we),     32'(c_we));
    checkOutput("rf_waddr",  32'(rf_waddr),  32'(c_addr));
    checkOutput("rf_wdata",  rf_wdata,       c_data);
    checkOutput("stall_o",   32'(stall_o),   32'(c_stall));
    checkOutput("aux_ready", 32'(aux_ready), 32'(c_ready));
    checkOutput("pend1",     32'(pend1),     32'(c_p1));
    checkOutput("pend2",     32'(pend2),     32'(c_p2));
  end

  logic        u_we, u_stall, u_ready, u_p1, u_p2, u_pop, u_acc, u_empty;
  logic [4:0]  u_addr;
  logic [31:0] u_data;

  always @(posedge clk) begin
    modelComb(u_we, u_addr, u_data, u_stall, u_ready, u_p1, u_p2, u_pop, u_acc);
    if (rst) begin
      mq.delete();
      mwait = 0;
    end else begin
      u_empty = (mq.size() == 0);
      if (u_pop) void'(mq.pop_front());
      if (u_acc && aux_waddr != 0) mq.push_back({aux_waddr, aux_wdata});
      if (u_pop || u_empty) mwait = 0;
      else if (mwait < MAX_WAIT) mwait++;
    end
  end

  task automatic applyStimulus(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    aux_valid = av; aux_waddr = aa; aux_wdata = ad;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  int found;

  initial begin
    rst = 1'b1;
    idle();
    advance();
    advance();
    rst = 1'b0;
    settle();
    checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
    checkOutput("reset_aux_ready", 32'(aux_ready), 32'd1);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    advance();

    // Aux write into an idle port lands the following cycle.
    applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 0);
    settle();
    checkOutput("idle_accept_pend1", 32'(pend1), 32'd1);
    checkOutput("idle_accept_rf_we", 32'(rf_we), 32'd0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    settle();
    checkOutput("idle_write_rf_we", 32'(rf_we), 32'd1);
    checkOutput("idle_write_waddr", 32'(rf_waddr), 32'd5);
    checkOutput("idle_write_wdata", rf_wdata, 32'hDEADBEEF);
    checkOutput("idle_write_pend1", 32'(pend1), 32'd0);
    advance();

    // Pipe keeps priority while the FIFO fills.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5'd3, $urandom, 1, 5'(8 + i), 32'h100 + 32'(i), 0, 0, 0, 0);
      settle();
      checkOutput("fill_pipe_waddr", 32'(rf_waddr), 32'd3);
      checkOutput("fill_aux_ready", 32'(aux_ready), 32'd1);
      advance();
    end
    applyStimulus(1, 5'd3, $urandom, 1, 5'd12, 32'h555, 1, 5'd10, 1, 5'd12);
    settle();
    checkOutput("full_aux_ready", 32'(aux_ready), 32'd0);
    checkOutput("full_pend1", 32'(pend1), 32'd1);
    checkOutput("full_pend2", 32'(pend2), 32'd0);
    checkOutput("full_pipe_waddr", 32'(rf_waddr), 32'd3);
    advance();

    // Drop the pipe with aux still pushing: pop per cycle, ready returns one cycle later.
    applyStimulus(0, 0, 0, 1, 5'd16, 32'h600, 0, 0, 0, 0);
    settle();
    checkOutput("drain_ready_first", 32'(aux_ready), 32'd0);
    checkOutput("drain_waddr_first", 32'(rf_waddr), 32'd8);
    checkOutput("drain_wdata_first", rf_wdata, 32'h100);
    advance();
    applyStimulus(0, 0, 0, 1, 5'd17, 32'h601, 0, 0, 0, 0);
    settle();
    checkOutput("drain_ready_second", 32'(aux_ready), 32'd1);
    checkOutput("drain_waddr_second", 32'(rf_waddr), 32'd9);
    advance();
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, 0, 1, 5'(18 + k), $urandom, 1, 5'(18 + k), 0, 0);
      advance();
    end
    idle();
    for (int k = 0; k < 6; k++) advance();

    // A single entry blocked by a busy pipe is forced out MAX_WAIT+1 cycles later.
    applyStimulus(1, 5'd3, $urandom, 1, 5'd20, 32'hABCD0020, 0, 0, 0, 0);
    advance();
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1, 5'd3, $urandom, 0, 0, 0, 0, 0, 0, 0);
      settle();
      if (stall_o && found == 0) begin
        found = k;
        checkOutput("starve_waddr", 32'(rf_waddr), 32'd20);
        checkOutput("starve_wdata", rf_wdata, 32'hABCD0020);
      end
      advance();
    end
    checkOutput("starve_cycle", 32'(found), 32'd9);

    // Zero-address handling on both sides.
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h77, 0, 0, 0, 0);
    settle();
    checkOutput("zero_aux_ready", 32'(aux_ready), 32'd1);
    advance();
    idle();
    settle();
    checkOutput("zero_aux_no_write", 32'(rf_we), 32'd0);
    advance();
    applyStimulus(1, 5'd3, $urandom, 1, 5'd7, 32'h7777, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 5'd0, 32'h99, 0, 0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("zero_pipe_rf_we", 32'(rf_we), 32'd1);
    checkOutput("zero_pipe_waddr", 32'(rf_waddr), 32'd7);
    checkOutput("zero_pipe_wdata", rf_wdata, 32'h7777);
    advance();

    // Reset with three queued entries throws them all away.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd3, $urandom, 1, 5'(21 + i), $urandom, 0, 0, 0, 0);
      advance();
    end
    rst = 1'b1;
    applyStimulus(1, 5'd3, $urandom, 1, 5'd24, $urandom, 1, 5'd21, 1, 5'd22);
    settle();
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_aux_ready", 32'(aux_ready), 32'd0);
    checkOutput("rst_pend1", 32'(pend1), 32'd0);
    advance();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd21, 1, 5'd22);
    settle();
    checkOutput("post_rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("post_rst_aux_ready", 32'(aux_ready), 32'd1);
    checkOutput("post_rst_pend1", 32'(pend1), 32'd0);
    checkOutput("post_rst_pend2", 32'(pend2), 32'd0);
    advance();
    for (int k = 0; k < 3; k++) begin
      settle();
      checkOutput("post_rst_no_stale", 32'(rf_we), 32'd0);
      advance();
    end

    // Randomized traffic with small address range to provoke pending hits.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      applyStimulus(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      advance();
    end
    rst = 1'b0;
    idle();
    for (int k = 0; k < 12; k++) advance();
    settle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline write-back and a long-latency auxiliary unit (divider / multi-cycle load).
- Aux results are queued in a small FIFO and written in idle write-back slots.
- A starvation counter forces a one-cycle pipeline stall so queued results always drain.
- Reports pending-write hits so decode can stall on reads of registers with queued results.

Parameters:
- DEPTH, 4: aux FIFO entries; power of 2, minimum 2.
- MAX_WAIT, 8: consecutive blocked cycles of a non-empty FIFO before a forced stall; minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pipe_we  in  1  pipeline write-back request.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline result.
- aux_valid  in  1  aux result valid.
- aux_waddr  in  5  aux destination register.
- aux_wdata  in  32  aux result.
- aux_ready  out  1  FIFO can accept this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- stall_o  out  1  forced write-back stall; pipeline holds its WB stage.
- re1  in  1  decode read enable, port 1.
- raddr1  in  5  decode read address, port 1.
- re2  in  1  decode read enable, port 2.
- raddr2  in  5  decode read address, port 2.
- pend1  out  1  raddr1 has a queued aux write.
- pend2  out  1  raddr2 has a queued aux write.

Behaviour:
- Reset: FIFO emptied (pointers and count 0), wait_cnt=0.
- While rst=1: rf_we=0, rf_waddr=0, rf_wdata=0, stall_o=0, aux_ready=0, pend1=pend2=0.
- aux_ready = !full. It is not raised by a same-cycle pop.
- An accept occurs when aux_valid && aux_ready. Accepted entries with aux_waddr=0 are discarded and not enqueued.
- Write-port grant is combinational. Priority per cycle:
  1. starve = (wait_cnt==MAX_WAIT) && !empty: stall_o=1; grant FIFO head and pop; pipe request ignored and must be re-presented next cycle.
  2. Otherwise, pipe_we && pipe_waddr!=0: grant pipe; rf_* = pipe_*.
  3. Otherwise, !empty: grant FIFO head and pop.
  4. Otherwise: rf_we=0, rf_waddr=0, rf_wdata=0.
- A pipe write to $0 counts as no request, so the slot goes to aux.
- Aux latency: an entry accepted in cycle N is written no earlier than cycle N+1. With an idle pipe it is written exactly at N+1.
- FIFO order is strictly FIFO. Simultaneous push and pop are legal at any non-full count, and the count is unchanged. Pointers wrap modulo DEPTH.
- wait_cnt:
  - Cleared on any pop or when empty.
  - Otherwise increments when the FIFO is non-empty and not popped; saturates at MAX_WAIT.
  - Effect: a head entry waits at most MAX_WAIT+1 cycles.
- pend1 = re1 && raddr1!=0 && raddr1 matches any of:
  - a valid FIFO entry, excluding the entry popped this cycle (covered by register file write bypass);
  - the aux entry accepted this cycle.
  pend2 is identical for port 2.
- WAW ordering between pipe and aux writes to the same register is enforced by decode using pend*. The arbiter does not reorder or drop entries.
- Reset asserted mid-operation discards all queued entries at that edge. No write is issued in the reset cycle.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- When defined, adds:
  - output stat_stall (32 bits): count of cycles with stall_o=1.
  - output stat_full (32 bits): count of cycles with aux_valid && !aux_ready.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Aux write to idle port: reset, then aux_valid with waddr=5, wdata=0xDEADBEEF, pipe_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pend1 with raddr1=5 is 1 only in the accept cycle.
- Pipe priority and FIFO fill: pipe_we=1 every cycle (waddr=3), 4 aux pushes to regs 8..11 -> all pipe writes granted; aux_ready=0 after 4th accept (DEPTH=4); pend1=1 for raddr1=10.
- Starvation: FIFO holds 1 entry while pipe writes continuously -> stall_o=1 exactly 9 cycles after the enqueue (MAX_WAIT=8); that cycle writes the aux entry and wait_cnt returns to 0.
- $0 handling: aux_valid with waddr=0 -> accepted, no rf write, FIFO stays empty. pipe_we=1 with pipe_waddr=0 and FIFO non-empty -> aux head granted.
- Full + simultaneous push/pop: fill FIFO, drop pipe_we, keep aux_valid=1 -> one pop per cycle, aux_ready=1 from the cycle after the first pop, data emerges in enqueue order including wrap-around.
- Reset mid-operation: rst=1 with 3 queued entries -> following cycle rf_we=0, aux_ready=1, pend1=pend2=0, no stale writes ever appear.
